// File: rtl/alarm_input_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_input_ctrl
//
// Input-side front end for the alarm clock. Conditions the two active-low push
// buttons and the switch bank into clean, single-cycle commands for the alarm
// controller running in the same clock domain.
//
//   - start_b / reset_b are synchronised (2 flops) and debounced independently.
//   - An accepted start latches switches[9:1] as total_time and switches[0] as
//     speed and raises start_pulse, unless the duration is zero, in which case
//     zero_err pulses and the latched values are left alone.
//   - An accepted clear raises clear_pulse; it wins over a start accepted on
//     the same cycle.
//
// Optional feature (compile-time macro ALARM_INPUT_HOLD_EN):
//   When defined, keeping the clear button pressed for HOLD_CYCLES cycles after
//   its acceptance raises hold_pulse once per press. When undefined, the hold
//   logic is not built, hold_pulse is tied low and the debounce counters are
//   only as wide as DEBOUNCE_CYCLES needs.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a level change (>= 2)
//   HOLD_CYCLES      clear-button hold duration for hold_pulse (>= DEBOUNCE_CYCLES)
//
// Ports
//   clk          base clock, rising edge
//   reset        asynchronous, active-high reset
//   switches     raw switch bank: [0] speed select, [9:1] duration
//   start_b      raw start button, active low, asynchronous
//   reset_b      raw clear button, active low, asynchronous
//   total_time   duration latched at the last accepted start
//   speed        speed select latched at the last accepted start
//   start_pulse  one-cycle pulse: start accepted, total_time/speed valid
//   clear_pulse  one-cycle pulse: clear accepted
//   zero_err     one-cycle pulse: start accepted with duration 0
//   hold_pulse   one-cycle pulse: clear held for HOLD_CYCLES
// -----------------------------------------------------------------------------
module alarm_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HOLD_CYCLES     = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] switches,
  input  logic       start_b,
  input  logic       reset_b,
  output logic [8:0] total_time,
  output logic       speed,
  output logic       start_pulse,
  output logic       clear_pulse,
  output logic       zero_err,
  output logic       hold_pulse
);

`ifdef ALARM_INPUT_HOLD_EN
  localparam int CW = $clog2(HOLD_CYCLES + 1);
`else
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
`endif

  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

`ifdef ALARM_INPUT_HOLD_EN
  // The clear counter parks at HOLD_DONE once the hold pulse has fired, so a
  // long press (or a bounce back into PRESSED) cannot fire it again.
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_DONE  = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] RESUME_CNT = HOLD_DONE;
`else
  localparam logic [CW-1:0] RESUME_CNT = '0;
`endif

  // Reject parameter sets the debouncers cannot honour.
  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < DEBOUNCE_CYCLES) begin : g_param_check
    $error("alarm_input_ctrl: need DEBOUNCE_CYCLES >= 2 and HOLD_CYCLES >= DEBOUNCE_CYCLES");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } deb_state_t;

  logic [1:0]    start_sync;
  logic [1:0]    clear_sync;
  logic          start_lvl;
  logic          clear_lvl;

  deb_state_t    start_state;
  logic [CW-1:0] start_cnt;
  logic          start_stable;

  deb_state_t    clear_state;
  logic [CW-1:0] clear_cnt;
  logic          clear_stable;

  logic          start_fire;
  logic          clear_fire;

  // Two-flop synchronisers; reset to 1 so a button reads as released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_sync <= 2'b11;
      clear_sync <= 2'b11;
    end else begin
      start_sync <= {start_sync[0], start_b};
      clear_sync <= {clear_sync[0], reset_b};
    end
  end

  assign start_lvl = start_sync[1];
  assign clear_lvl = clear_sync[1];

  // A press is accepted on the edge where PRESS_WAIT has seen the new level
  // for the full debounce window; the output register below captures the
  // switches on that same edge.
  assign start_fire = (start_state == PRESS_WAIT) && !start_lvl && (start_cnt == DEB_LAST);
  assign clear_fire = (clear_state == PRESS_WAIT) && !clear_lvl && (clear_cnt == DEB_LAST);

  // Start button debouncer. stable holds the last accepted level; any
  // difference from it starts (or continues) a debounce window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_state  <= IDLE;
      start_cnt    <= '0;
      start_stable <= 1'b1;
    end else begin
      case (start_state)
        IDLE: begin
          if (start_lvl != start_stable) begin
            start_state <= PRESS_WAIT;
            start_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (start_lvl == start_stable) begin
            start_state <= IDLE;
            start_cnt   <= '0;
          end else if (start_cnt == DEB_LAST) begin
            start_state  <= PRESSED;
            start_cnt    <= '0;
            start_stable <= 1'b0;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (start_lvl != start_stable) begin
            start_state <= RELEASE_WAIT;
            start_cnt   <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (start_lvl == start_stable) begin
            start_state <= PRESSED;
            start_cnt   <= '0;
          end else if (start_cnt == DEB_LAST) begin
            start_state  <= IDLE;
            start_cnt    <= '0;
            start_stable <= 1'b1;
          end else begin
            start_cnt <= start_cnt + 1'b1;
          end
        end
        default: begin
          start_state <= IDLE;
          start_cnt   <= '0;
        end
      endcase
    end
  end

  // Clear button debouncer. Same structure as the start one; with the hold
  // feature built, the counter restarts at acceptance and keeps running while
  // the button stays pressed, saturating at HOLD_DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clear_state  <= IDLE;
      clear_cnt    <= '0;
      clear_stable <= 1'b1;
    end else begin
      case (clear_state)
        IDLE: begin
          if (clear_lvl != clear_stable) begin
            clear_state <= PRESS_WAIT;
            clear_cnt   <= '0;
          end
        end
        PRESS_WAIT: begin
          if (clear_lvl == clear_stable) begin
            clear_state <= IDLE;
            clear_cnt   <= '0;
          end else if (clear_cnt == DEB_LAST) begin
            clear_state  <= PRESSED;
            clear_cnt    <= '0;
            clear_stable <= 1'b0;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (clear_lvl != clear_stable) begin
            clear_state <= RELEASE_WAIT;
            clear_cnt   <= '0;
          end
`ifdef ALARM_INPUT_HOLD_EN
          else if (clear_cnt != HOLD_DONE) begin
            clear_cnt <= clear_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (clear_lvl == clear_stable) begin
            clear_state <= PRESSED;
            clear_cnt   <= RESUME_CNT;
          end else if (clear_cnt == DEB_LAST) begin
            clear_state  <= IDLE;
            clear_cnt    <= '0;
            clear_stable <= 1'b1;
          end else begin
            clear_cnt <= clear_cnt + 1'b1;
          end
        end
        default: begin
          clear_state <= IDLE;
          clear_cnt   <= '0;
        end
      endcase
    end
  end

  // Command outputs. Clear takes priority: a start accepted on the same edge
  // is dropped entirely, including its zero-duration check and latch update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_time  <= '0;
      speed       <= 1'b0;
      start_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      zero_err    <= 1'b0;
    end else begin
      start_pulse <= 1'b0;
      clear_pulse <= 1'b0;
      zero_err    <= 1'b0;
      if (clear_fire) begin
        clear_pulse <= 1'b1;
      end else if (start_fire) begin
        if (switches[9:1] != 9'd0) begin
          start_pulse <= 1'b1;
          total_time  <= switches[9:1];
          speed       <= switches[0];
        end else begin
          zero_err <= 1'b1;
        end
      end
    end
  end

`ifdef ALARM_INPUT_HOLD_EN
  logic hold_fire;

  assign hold_fire = (clear_state == PRESSED) && !clear_lvl && (clear_cnt == HOLD_LAST);

  // Registered so hold_pulse lines up with the other command pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_pulse <= 1'b0;
    end else begin
      hold_pulse <= hold_fire;
    end
  end
`else
  assign hold_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_input_ctrl
//
// Self-checking bench for alarm_input_ctrl with DEBOUNCE_CYCLES=4 and
// HOLD_CYCLES=20. A cycle-by-cycle vector table covers the basic start press,
// held-button behaviour, switch changes after latching and a second press;
// hand-written sequences cover glitches, zero duration, simultaneous presses,
// reset mid-debounce and clear-button hold.
// -----------------------------------------------------------------------------
module tb_alarm_input_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 20;
  localparam int NVEC = 26;

  localparam logic [9:0] SW_A = 10'b0000001011;
  localparam logic [9:0] SW_B = 10'b1111111110;
  localparam logic [9:0] SW_C = 10'b0000000100;
  localparam logic [9:0] SW_Z = 10'b0000000001;
  localparam logic [9:0] SW_S = 10'b0000011111;
  localparam logic [9:0] SW_R = 10'b0000000111;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] switches;
  logic       start_b;
  logic       reset_b;
  logic [8:0] total_time;
  logic       speed;
  logic       start_pulse;
  logic       clear_pulse;
  logic       zero_err;
  logic       hold_pulse;

  typedef struct {
    logic       sb;
    logic [9:0] sw;
    logic       exp_start;
    logic [8:0] exp_tt;
    logic       exp_spd;
  } vec_t;

  vec_t vecs[NVEC];

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  int n_start, n_clear, n_zero, n_hold;
  int clear_at, hold_at;

  alarm_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .switches(switches),
    .start_b(start_b),
    .reset_b(reset_b),
    .total_time(total_time),
    .speed(speed),
    .start_pulse(start_pulse),
    .clear_pulse(clear_pulse),
    .zero_err(zero_err),
    .hold_pulse(hold_pulse)
  );

  always #5 clk = ~clk;

  function automatic vec_t mkVec(input logic sb, input logic [9:0] sw, input logic es,
                                 input logic [8:0] tt, input logic spd);
    vec_t v;
    v.sb = sb;
    v.sw = sw;
    v.exp_start = es;
    v.exp_tt = tt;
    v.exp_spd = spd;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic clearCounts();
    n_start = 0; n_clear = 0; n_zero = 0; n_hold = 0;
    clear_at = -1; hold_at = -1;
  endtask

  // Drive inputs on a falling edge, let one rising edge consume them, and
  // tally the pulses visible at the following falling edge.
  task automatic applyStimulus(input logic sb, input logic rb, input logic [9:0] sw);
    start_b  = sb;
    reset_b  = rb;
    switches = sw;
    @(negedge clk);
    cyc++;
    if (start_pulse) n_start++;
    if (clear_pulse) begin n_clear++; clear_at = cyc; end
    if (zero_err) n_zero++;
    if (hold_pulse) begin n_hold++; hold_at = cyc; end
  endtask

  initial begin
    // Press from edge 0 with duration 5/speed 1: pulse after edge 6.
    for (int i = 0; i < 6; i++) vecs[i] = mkVec(1'b0, SW_A, 1'b0, 9'd0, 1'b0);
    vecs[6] = mkVec(1'b0, SW_A, 1'b1, 9'd5, 1'b1);
    // Still held, switches change: no re-pulse, latch unaffected.
    for (int i = 7; i < 11; i++) vecs[i] = mkVec(1'b0, SW_B, 1'b0, 9'd5, 1'b1);
    // Release and let the release debounce finish.
    for (int i = 11; i < 19; i++) vecs[i] = mkVec(1'b1, SW_B, 1'b0, 9'd5, 1'b1);
    // Second press with duration 2/speed 0.
    for (int i = 19; i < 25; i++) vecs[i] = mkVec(1'b0, SW_C, 1'b0, 9'd5, 1'b1);
    vecs[25] = mkVec(1'b0, SW_C, 1'b1, 9'd2, 1'b0);

    clearCounts();
    reset    = 1'b1;
    start_b  = 1'b1;
    reset_b  = 1'b1;
    switches = SW_A;
    repeat (2) @(negedge clk);
    checkOutput("reset_state",
                {18'd0, start_pulse, clear_pulse, zero_err, hold_pulse, speed, total_time}, 32'd0);
    reset = 1'b0;
    repeat (3) applyStimulus(1'b1, 1'b1, SW_A);

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].sb, 1'b1, vecs[i].sw);
      checkOutput($sformatf("vec%0d", i),
                  {20'd0, start_pulse, clear_pulse, zero_err, total_time, speed},
                  {20'd0, vecs[i].exp_start, 1'b0, 1'b0, vecs[i].exp_tt, vecs[i].exp_spd});
    end
    repeat (10) applyStimulus(1'b1, 1'b1, SW_C);

    // Short glitch: three cycles low is below the debounce window.
    clearCounts();
    repeat (3) applyStimulus(1'b0, 1'b1, SW_A);
    repeat (10) applyStimulus(1'b1, 1'b1, SW_A);
    checkOutput("glitch_start_count", n_start, 0);
    checkOutput("glitch_total_time", total_time, 9'd2);

    // Zero duration: zero_err once, no start, latch keeps prior values.
    clearCounts();
    repeat (10) applyStimulus(1'b0, 1'b1, SW_Z);
    repeat (10) applyStimulus(1'b1, 1'b1, SW_Z);
    checkOutput("zero_err_count", n_zero, 1);
    checkOutput("zero_start_count", n_start, 0);
    checkOutput("zero_total_time", total_time, 9'd2);
    checkOutput("zero_speed", speed, 1'b0);

    // Both buttons on the same edge: clear wins, start is discarded.
    clearCounts();
    repeat (10) applyStimulus(1'b0, 1'b0, SW_S);
    repeat (10) applyStimulus(1'b1, 1'b1, SW_S);
    checkOutput("simul_clear_count", n_clear, 1);
    checkOutput("simul_start_count", n_start, 0);
    checkOutput("simul_zero_count", n_zero, 0);
    checkOutput("simul_total_time", total_time, 9'd2);

    // Reset two cycles into PRESS_WAIT with start_b kept low.
    clearCounts();
    repeat (3) applyStimulus(1'b0, 1'b1, SW_R);
    reset = 1'b1;
    #1;
    checkOutput("reset_async_latch", {23'd0, total_time, speed}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    clearCounts();
    repeat (6) applyStimulus(1'b0, 1'b1, SW_R);
    checkOutput("rst_no_early_pulse", n_start, 0);
    applyStimulus(1'b0, 1'b1, SW_R);
    checkOutput("rst_pulse_at_6", start_pulse, 1'b1);
    checkOutput("rst_total_time", total_time, 9'd3);
    checkOutput("rst_speed", speed, 1'b1);
    repeat (10) applyStimulus(1'b0, 1'b1, SW_R);
    checkOutput("rst_start_once", n_start, 1);
    repeat (10) applyStimulus(1'b1, 1'b1, SW_R);

    // Clear held for 40 cycles.
    clearCounts();
    repeat (40) applyStimulus(1'b1, 1'b0, SW_A);
    repeat (10) applyStimulus(1'b1, 1'b1, SW_A);
    checkOutput("hold_clear_count", n_clear, 1);
    checkOutput("hold_total_time", total_time, 9'd3);
`ifdef ALARM_INPUT_HOLD_EN
    checkOutput("hold_pulse_count", n_hold, 1);
    checkOutput("hold_pulse_delay", hold_at - clear_at, HOLD);
`else
    checkOutput("hold_pulse_count", n_hold, 0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/alarm_input_ctrl.md
# alarm_input_ctrl

Input-side front end for the alarm clock: conditions the two active-low push buttons and the switch bank into clean, single-cycle commands for the alarm controller. It synchronises and debounces `start_b` and `reset_b`, emits one-cycle press pulses, and latches the switch-selected duration and speed at the moment a start is accepted. It sits between the board pins and the alarm controller, which consumes its outputs in the same clock domain.

## Interface
- `DEBOUNCE_CYCLES`, default 50000, consecutive stable cycles required to accept a button level change (≥2).
- `HOLD_CYCLES`, default 100000000, press duration on `reset_b` that produces `hold_pulse` (≥`DEBOUNCE_CYCLES`).
- `clk`  in  1  base clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `switches`  in  10  raw switch bank; [0] speed select, [9:1] duration.
- `start_b`  in  1  raw start button, active low, asynchronous to `clk`.
- `reset_b`  in  1  raw clear button, active low, asynchronous to `clk`.
- `total_time`  out  9  duration latched at last accepted start.
- `speed`  out  1  speed select latched at last accepted start.
- `start_pulse`  out  1  one-cycle pulse: start accepted, `total_time`/`speed` valid.
- `clear_pulse`  out  1  one-cycle pulse: clear accepted.
- `zero_err`  out  1  one-cycle pulse: start pressed with duration 0.
- `hold_pulse`  out  1  one-cycle pulse: clear held for `HOLD_CYCLES` (see Configuration).

## Operation
- Each button: 2-flop synchroniser (reset value 1 = released), then a per-button debouncer with a stable-level register (reset 1) and a counter of width ceil(log2(`HOLD_CYCLES`+1)).
- Debouncer FSM states: IDLE (stable released), PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE → PRESS_WAIT when synchronised level = 0; counter cleared.
  - PRESS_WAIT: counter increments each cycle level = 0; level returns to 1 before count reaches `DEBOUNCE_CYCLES` → IDLE, counter cleared, no pulse. Count reaches `DEBOUNCE_CYCLES` → PRESSED, press accepted.
  - PRESSED → RELEASE_WAIT when level = 1; symmetric debounce; on completion → IDLE. Level 0 during RELEASE_WAIT → back to PRESSED.
- Accepted start press: if `switches[9:1]` ≠ 0, `total_time` ← `switches[9:1]`, `speed` ← `switches[0]` on the same edge that raises `start_pulse`. If `switches[9:1]` = 0, `zero_err` pulses instead; `total_time`/`speed` unchanged; no `start_pulse`.
- Accepted clear press: `clear_pulse` for one cycle; latched `total_time`/`speed` unchanged.
- Simultaneous acceptance (same cycle): `clear_pulse` asserts, start is discarded (no `start_pulse`, no `zero_err`, no latch update).
- Held buttons never re-pulse; a new pulse requires a full release debounce followed by a new press debounce.
- At most one pulse per button per press; `start_pulse`, `zero_err` mutually exclusive.

## Timing
- Reset values: `total_time` = 0, `speed` = 0, all pulses 0, FSMs IDLE, counters 0, synchronisers 1.
- Press latency: button first sampled low at edge N (stable thereafter) → pulse high for exactly the cycle after edge N+2+`DEBOUNCE_CYCLES`.
- Switch values are sampled at the edge that raises `start_pulse`; changes afterwards do not affect `total_time`.
- Glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles: no output effect.
- Reset asserted mid-debounce or mid-hold: everything returns to reset values immediately; a button still held at reset release must be debounced afresh and then pulses once.

## Configuration
- `ALARM_INPUT_HOLD_EN` defined: in PRESSED for the clear button, counter keeps counting from acceptance; on reaching `HOLD_CYCLES`, `hold_pulse` asserts for one cycle (once per press), alongside the earlier `clear_pulse`.
- Not defined: hold logic not compiled; `hold_pulse` tied 0; counter width reduced to ceil(log2(`DEBOUNCE_CYCLES`+1)).

## Test plan
- `DEBOUNCE_CYCLES`=4, switches=10'b0000001011, `start_b` low from edge 0 → `start_pulse` high only after edge 6, `total_time`=5, `speed`=1.
- `start_b` low for 3 cycles then high (DEBOUNCE_CYCLES=4) → no pulse, `total_time` unchanged.
- switches[9:1]=0, start pressed → `zero_err` one cycle, no `start_pulse`, `total_time` keeps prior value.
- Both buttons pressed on same edge → `clear_pulse` one cycle, no `start_pulse`, no latch.
- `reset` asserted 2 cycles into PRESS_WAIT while `start_b` stays low → outputs 0; after release, `start_pulse` 2+4 edges later, once.
- With `ALARM_INPUT_HOLD_EN`, HOLD_CYCLES=20, `reset_b` held 40 cycles → one `clear_pulse`, one `hold_pulse` 20 cycles later; without macro, `hold_pulse` stays 0.
